poseidon_top_level: RTL and testbench

Streaming Poseidon-style sponge hash over the BLS12-381 scalar field, p = 0x73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001. It absorbs a message of 255-bit field elements on a valid/ready input stream, framed by `last`, and emits a one-beat 255-bit digest on a valid/ready output stream. The block is the top-level hash core and sits between a message producer and a digest consumer.

---
 rtl/poseidon_top_level_if.sv | 21 ++
 rtl/poseidon_top_level.sv | 210 +++++++++++++++++++++
 tb/tb_poseidon_top_level.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poseidon_top_level_if.sv
// Message-in / digest-out stream bundle for the Poseidon sponge core.
interface poseidon_top_level_if;
    logic         io_input_valid;
    logic         io_input_ready;
    logic         io_input_last;
    logic [254:0] io_input_payload;
    logic         io_output_valid;
    logic         io_output_ready;
    logic         io_output_last;
    logic [254:0] io_output_payload;

    modport master (
        output io_input_valid, io_input_last, io_input_payload, io_output_ready,
        input  io_input_ready, io_output_valid, io_output_last, io_output_payload
    );

    modport slave (
        input  io_input_valid, io_input_last, io_input_payload, io_output_ready,
        output io_input_ready, io_output_valid, io_output_last, io_output_payload
    );
endinterface

// File: rtl/poseidon_top_level.sv
// Streaming Poseidon-style sponge hash over the BLS12-381 scalar field, 3 lanes,
// one shared bit-serial modular multiplier.
module poseidon_top_level #(
    parameter int unsigned RF = 8,
    parameter int unsigned RP = 57
) (
    input logic                 clk,
    input logic                 resetn,
    poseidon_top_level_if.slave io
);
    localparam int unsigned R       = RF + RP;
    localparam int          HalfRf  = int'(RF / 2);
    localparam int          PartEnd = int'(RF / 2 + RP);
    localparam logic [255:0] P  =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
    localparam logic [256:0] P1 = {1'b0, P};
    localparam logic [256:0] P2 = {P, 1'b0};

    localparam logic [1:0] StAbsorb  = 2'd0;
    localparam logic [1:0] StPermute = 2'd1;
    localparam logic [1:0] StOutput  = 2'd2;

    localparam logic [1:0] PhStart = 2'd0;
    localparam logic [1:0] PhArc   = 2'd1;
    localparam logic [1:0] PhMul   = 2'd2;
    localparam logic [1:0] PhMds   = 2'd3;

    logic [1:0]   state_q, state_d, phase_q, phase_d;
    logic         ready_q, ready_d, odd_q, odd_d, last_q, last_d;
    logic [254:0] lane_q [3];
    logic [254:0] lane_d [3];
    logic [254:0] t_q, t_d, acc_q, acc_d, mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [7:0]   round_q, round_d, cnt_q, cnt_d;
    logic [1:0]   sel_q, sel_d, step_q, step_d;

    function automatic logic [254:0] add_mod(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= P) s = s - P;
        return s[254:0];
    endfunction

    // A 255-bit input is below 3p, so two conditional subtractions suffice.
    function automatic logic [254:0] reduce_in(input logic [254:0] x);
        logic [255:0] v;
        v = {1'b0, x};
        if (v >= P) v = v - P;
        if (v >= P) v = v - P;
        return v[254:0];
    endfunction

    int           rnd_i;
    logic [31:0]  rc_base;
    logic         full_round, last_round;
    logic [256:0] dbl_add;
    logic [254:0] mul_next, mds_sum, ld_a, ld_b;
    logic [1:0]   done_state;

    // Round decode, multiplier step and operand selection.
    always_comb begin
        rnd_i      = int'(round_q);
        rc_base    = {24'd0, round_q} * 32'd3 + 32'd1;
        full_round = (rnd_i < HalfRf) || (rnd_i >= PartEnd);
        last_round = (rnd_i == int'(R) - 1);
        // acc < p and a < p, so 2*acc + a < 3p.
        dbl_add = {1'b0, acc_q, 1'b0} + {2'b0, (mul_b_q[254] ? mul_a_q : 255'd0)};
        if (dbl_add >= P2)      dbl_add = dbl_add - P2;
        else if (dbl_add >= P1) dbl_add = dbl_add - P1;
        mul_next = dbl_add[254:0];
        mds_sum  = add_mod(add_mod(lane_q[0], lane_q[1]), lane_q[2]);
        // Per-lane x^5 chain: x*x -> t, t*t -> t, t*x -> lane.
        case (step_q)
            2'd0:    begin ld_a = lane_q[sel_q]; ld_b = lane_q[sel_q]; end
            2'd1:    begin ld_a = t_q;           ld_b = t_q;           end
            default: begin ld_a = t_q;           ld_b = lane_q[sel_q]; end
        endcase
        done_state = last_q ? StOutput : StAbsorb;
    end

    // Next-state logic: absorb, permutation sequencing, digest hand-off.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        odd_d   = odd_q;
        last_d  = last_q;
        lane_d  = lane_q;
        t_d     = t_q;
        acc_d   = acc_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        step_d  = step_q;
        case (state_q)
            StAbsorb: begin
                if (io.io_input_valid && ready_q) begin
                    if (odd_q) lane_d[2] = add_mod(lane_q[2], reduce_in(io.io_input_payload));
                    else       lane_d[1] = add_mod(lane_q[1], reduce_in(io.io_input_payload));
                    odd_d  = ~odd_q;
                    last_d = io.io_input_last;
                    if (odd_q || io.io_input_last) begin
                        state_d = StPermute;
                        phase_d = PhStart;
                    end
                end
            end
            StPermute: begin
                case (phase_q)
                    PhStart: begin
                        round_d = 8'd0;
                        if (R == 0) state_d = done_state;
                        else        phase_d = PhArc;
                    end
                    PhArc: begin
                        for (int i = 0; i < 3; i++) begin
                            lane_d[i] = add_mod(lane_q[i], {223'd0, rc_base + 32'(i)});
                        end
                        phase_d = PhMul;
                        sel_d   = 2'd0;
                        step_d  = 2'd0;
                        cnt_d   = 8'd0;
                    end
                    PhMul: begin
                        if (cnt_q == 8'd0) begin
                            acc_d   = '0;
                            mul_a_d = ld_a;
                            mul_b_d = ld_b;
                            cnt_d   = 8'd1;
                        end else begin
                            acc_d   = mul_next;
                            mul_b_d = mul_b_q << 1;
                            cnt_d   = cnt_q + 8'd1;
                            if (cnt_q == 8'd255) begin
                                cnt_d = 8'd0;
                                if (step_q == 2'd2) begin
                                    lane_d[sel_q] = mul_next;
                                    step_d        = 2'd0;
                                    if (full_round && sel_q != 2'd2) sel_d = sel_q + 2'd1;
                                    else                             phase_d = PhMds;
                                end else begin
                                    t_d    = mul_next;
                                    step_d = step_q + 2'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        for (int i = 0; i < 3; i++) lane_d[i] = add_mod(mds_sum, lane_q[i]);
                        if (last_round) begin
                            state_d = done_state;
                        end else begin
                            round_d = round_q + 8'd1;
                            phase_d = PhArc;
                        end
                    end
                endcase
            end
            default: begin
                if (io.io_output_ready) begin
                    for (int i = 0; i < 3; i++) lane_d[i] = '0;
                    odd_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = StAbsorb;
                end
            end
        endcase
        ready_d = (state_d == StAbsorb);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StAbsorb;
            phase_q <= PhStart;
            ready_q <= 1'b0;
            odd_q   <= 1'b0;
            last_q  <= 1'b0;
            for (int i = 0; i < 3; i++) lane_q[i] <= '0;
            t_q     <= '0;
            acc_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            round_q <= 8'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 2'd0;
            step_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ready_q <= ready_d;
            odd_q   <= odd_d;
            last_q  <= last_d;
            lane_q  <= lane_d;
            t_q     <= t_d;
            acc_q   <= acc_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            step_q  <= step_d;
        end
    end

    assign io.io_input_ready    = ready_q;
    assign io.io_output_valid   = (state_q == StOutput);
    assign io.io_output_last    = (state_q == StOutput);
    assign io.io_output_payload = (state_q == StOutput) ? lane_q[1] : '0;
endmodule

// File: tb/tb_poseidon_top_level.sv
// Randomized bench for poseidon_top_level: three small round configurations run
// back to back, and the default configuration runs alongside them.
module tb_poseidon_top_level;
    localparam logic [255:0] P =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
    localparam int BOUND = 70000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter; read at a falling edge it is the index of the last rising edge.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic         rstn      [3];
    logic         in_valid  [3];
    logic         in_last   [3];
    logic [254:0] in_pay    [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_last  [3];
    logic [254:0] out_pay   [3];
    logic         rstn_c;

    poseidon_top_level_if ifs [3] ();
    poseidon_top_level_if ifc ();

    for (genvar g = 0; g < 3; g++) begin : g_bind
        assign ifs[g].io_input_valid   = in_valid[g];
        assign ifs[g].io_input_last    = in_last[g];
        assign ifs[g].io_input_payload = in_pay[g];
        assign ifs[g].io_output_ready  = out_ready[g];
        assign in_ready[g]  = ifs[g].io_input_ready;
        assign out_valid[g] = ifs[g].io_output_valid;
        assign out_last[g]  = ifs[g].io_output_last;
        assign out_pay[g]   = ifs[g].io_output_payload;
    end

    poseidon_top_level #(.RF(0), .RP(0)) u_dut0 (.clk(clk), .resetn(rstn[0]), .io(ifs[0]));
    poseidon_top_level #(.RF(2), .RP(0)) u_dut1 (.clk(clk), .resetn(rstn[1]), .io(ifs[1]));
    poseidon_top_level #(.RF(2), .RP(2)) u_dut2 (.clk(clk), .resetn(rstn[2]), .io(ifs[2]));
    poseidon_top_level #(.RF(8), .RP(57)) u_dutc (.clk(clk), .resetn(rstn_c), .io(ifc));

    task automatic check_eq(input string tag, input logic [254:0] got, input logic [254:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rf_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic int rp_of(input int d);
        return (d == 2) ? 2 : 0;
    endfunction

    function automatic int lat_of(input int d);
        return rf_of(d) * 2306 + rp_of(d) * 770;
    endfunction

    // ---------------- reference model: plain modular arithmetic ----------------
    function automatic logic [254:0] modp(input logic [254:0] x);
        logic [255:0] v;
        v = 256'(x) % P;
        return v[254:0];
    endfunction

    function automatic logic [254:0] addm(input logic [254:0] a, input logic [254:0] b);
        logic [255:0] v;
        v = (256'(a) + 256'(b)) % P;
        return v[254:0];
    endfunction

    function automatic logic [254:0] mulm(input logic [254:0] a, input logic [254:0] b);
        logic [511:0] w;
        w = (512'(a) * 512'(b)) % 512'(P);
        return w[254:0];
    endfunction

    function automatic logic [254:0] pow5(input logic [254:0] x);
        logic [254:0] x2;
        x2 = mulm(x, x);
        return mulm(mulm(x2, x2), x);
    endfunction

    function automatic logic [254:0] model_hash(input logic [254:0] msg [$], input int rf,
                                                input int rp);
        logic [254:0] s [3];
        logic [254:0] tot;
        for (int i = 0; i < 3; i++) s[i] = '0;
        for (int j = 0; j < msg.size(); j++) begin
            if (j % 2 == 0) s[1] = addm(s[1], modp(msg[j]));
            else            s[2] = addm(s[2], modp(msg[j]));
            if (j % 2 == 1 || j == msg.size() - 1) begin
                for (int r = 0; r < rf + rp; r++) begin
                    for (int i = 0; i < 3; i++) s[i] = addm(s[i], 255'(3 * r + i + 1));
                    for (int i = 0; i < 3; i++) begin
                        if (i == 0 || r < rf / 2 || r >= rf / 2 + rp) s[i] = pow5(s[i]);
                    end
                    tot = addm(addm(s[0], s[1]), s[2]);
                    for (int i = 0; i < 3; i++) s[i] = addm(tot, s[i]);
                end
            end
        end
        return s[1];
    endfunction

    function automatic logic [254:0] rand_elem();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v[254:0];
    endfunction

    // ---------------- drivers for the three small instances ----------------
    task automatic reset_check(input int d);
        rstn[d] = 1'b0;
        repeat (3) @(negedge clk);
        check_eq($sformatf("d%0d rst ready", d), 255'(in_ready[d]), 255'd0);
        check_eq($sformatf("d%0d rst valid", d), 255'(out_valid[d]), 255'd0);
        check_eq($sformatf("d%0d rst last", d), 255'(out_last[d]), 255'd0);
        check_eq($sformatf("d%0d rst payload", d), out_pay[d], 255'd0);
        rstn[d] = 1'b1;
        @(negedge clk);
        check_eq($sformatf("d%0d ready after rst", d), 255'(in_ready[d]), 255'd1);
    endtask

    task automatic send(input int d, input logic [254:0] x, input logic lst,
                        output int unsigned k);
        int n;
        n = 0;
        in_valid[d] = 1'b1;
        in_pay[d]   = x;
        in_last[d]  = lst;
        while (!in_ready[d] && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("d%0d accept", d), 255'(in_ready[d]), 255'd1);
        @(negedge clk);
        k = cyc;
        in_valid[d] = 1'b0;
        in_pay[d]   = rand_elem();
        in_last[d]  = 1'($urandom);
    endtask

    task automatic get_digest(input int d, input int unsigned k, input logic [254:0] exp,
                              input int stall);
        int n;
        n = 0;
        check_eq($sformatf("d%0d busy before digest", d), 255'(in_ready[d]), 255'd0);
        while (!out_valid[d] && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("d%0d out valid", d), 255'(out_valid[d]), 255'd1);
        check_eq($sformatf("d%0d latency", d), 255'(cyc - k), 255'(1 + lat_of(d)));
        check_eq($sformatf("d%0d digest", d), out_pay[d], exp);
        check_eq($sformatf("d%0d out last", d), 255'(out_last[d]), 255'd1);
        // Offer junk input while the digest is held; it must be refused.
        in_valid[d] = (stall > 0);
        repeat (stall) begin
            @(negedge clk);
            check_eq($sformatf("d%0d hold payload", d), out_pay[d], exp);
            check_eq($sformatf("d%0d hold valid", d), 255'(out_valid[d]), 255'd1);
            check_eq($sformatf("d%0d no input", d), 255'(in_ready[d]), 255'd0);
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check_eq($sformatf("d%0d valid drop", d), 255'(out_valid[d]), 255'd0);
        @(negedge clk);
        check_eq($sformatf("d%0d ready after out", d), 255'(in_ready[d]), 255'd1);
    endtask

    task automatic run_msg(input int d, input logic [254:0] msg [$], input logic [254:0] exp,
                           input int stall);
        int unsigned k;
        int          n;
        for (int j = 0; j < msg.size(); j++) begin
            logic lst;
            lst = (j == msg.size() - 1);
            send(d, msg[j], lst, k);
            if (!lst && j % 2 == 1) begin
                check_eq($sformatf("d%0d busy", d), 255'(in_ready[d]), 255'd0);
                n = 0;
                while (!in_ready[d] && n < BOUND) begin
                    @(negedge clk);
                    n++;
                end
                check_eq($sformatf("d%0d rearm", d), 255'(cyc - k), 255'(1 + lat_of(d)));
            end else if (!lst) begin
                check_eq($sformatf("d%0d no perm", d), 255'(in_ready[d]), 255'd1);
            end
        end
        get_digest(d, k, exp, stall);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rstn[d]      = 1'b0;
            in_valid[d]  = 1'b0;
            in_last[d]   = 1'b0;
            in_pay[d]    = '0;
            out_ready[d] = 1'b0;
        end
        rstn_c                  = 1'b0;
        ifc.io_input_valid      = 1'b0;
        ifc.io_input_last       = 1'b0;
        ifc.io_input_payload    = '0;
        ifc.io_output_ready     = 1'b0;

        fork
            begin : g_small
                logic [254:0] msg [$];
                logic [254:0] exp;
                int unsigned  k;
                int           bad;
                for (int d = 0; d < 3; d++) reset_check(d);

                // No rounds: pure rate-lane accumulation.
                msg = '{255'd5, 255'd7, 255'd9};
                run_msg(0, msg, 255'd14, 0);
                msg = '{P[254:0] + 255'd3};
                run_msg(0, msg, 255'd3, 1);
                msg = '{P[254:0] - 255'd1, 255'd4, 255'd2};
                run_msg(0, msg, 255'd1, 0);
                repeat (5) begin
                    msg.delete();
                    repeat ($urandom_range(1, 5)) msg.push_back(rand_elem());
                    run_msg(0, msg, model_hash(msg, 0, 0), int'($urandom_range(0, 3)));
                end

                // Two full rounds: known vector, then held output under back-pressure.
                msg = '{255'd0};
                check_eq("model zero vector", model_hash(msg, 2, 0), 255'd47644089759112);
                run_msg(1, msg, 255'd47644089759112, 3);

                // Abort mid-permutation, then rehash the same message.
                msg = '{rand_elem(), rand_elem()};
                exp = model_hash(msg, 2, 0);
                send(1, msg[0], 1'b0, k);
                send(1, msg[1], 1'b1, k);
                repeat (1000) @(negedge clk);
                rstn[1] = 1'b0;
                repeat (2) @(negedge clk);
                rstn[1] = 1'b1;
                @(negedge clk);
                check_eq("d1 abort ready", 255'(in_ready[1]), 255'd1);
                bad = 0;
                repeat (lat_of(1) + 20) begin
                    @(negedge clk);
                    if (out_valid[1]) bad++;
                end
                check_eq("d1 abort no digest", 255'(bad), 255'd0);
                run_msg(1, msg, exp, 1);

                // Full and partial rounds on random messages.
                repeat (2) begin
                    msg.delete();
                    repeat ($urandom_range(1, 3)) msg.push_back(rand_elem());
                    run_msg(2, msg, model_hash(msg, 2, 2), int'($urandom_range(0, 2)));
                end
            end
            begin : g_default
                int unsigned k;
                int          n;
                repeat (3) @(negedge clk);
                check_eq("dc rst ready", 255'(ifc.io_input_ready), 255'd0);
                check_eq("dc rst valid", 255'(ifc.io_output_valid), 255'd0);
                rstn_c = 1'b1;
                @(negedge clk);
                check_eq("dc ready after rst", 255'(ifc.io_input_ready), 255'd1);
                ifc.io_input_valid   = 1'b1;
                ifc.io_input_last    = 1'b0;
                ifc.io_input_payload = rand_elem();
                @(negedge clk);
                check_eq("dc even beat", 255'(ifc.io_input_ready), 255'd1);
                ifc.io_input_payload = rand_elem();
                @(negedge clk);
                k = cyc;
                ifc.io_input_valid = 1'b0;
                check_eq("dc busy", 255'(ifc.io_input_ready), 255'd0);
                n = 0;
                while (!ifc.io_input_ready && n < BOUND) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("dc rearm", 255'(cyc - k), 255'(1 + 8 * 2306 + 57 * 770));
                check_eq("dc no digest", 255'(ifc.io_output_valid), 255'd0);
                rstn_c = 1'b0;
                @(negedge clk);
                rstn_c = 1'b1;
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
